// File: rtl/regfile_sb_if.sv
// Bus between the ID/WB pipeline stages and the register file / scoreboard.
// The master drives read addresses, write-back, issue and flush; the slave returns data and busy flags.
interface regfile_sb_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic [ADDR_W-1:0] raddr1;
    logic [DATA_W-1:0] rdata1;
    logic              busy1;
    logic [ADDR_W-1:0] raddr2;
    logic [DATA_W-1:0] rdata2;
    logic              busy2;
    logic              we;
    logic [ADDR_W-1:0] waddr;
    logic [DATA_W-1:0] wdata;
    logic              iss_valid;
    logic [ADDR_W-1:0] iss_dst;
    logic              flush;
    logic [DATA_W-1:0] dbg_data;

    modport master (
        output raddr1, raddr2, we, waddr, wdata, iss_valid, iss_dst, flush,
        input  rdata1, busy1, rdata2, busy2, dbg_data
    );

    modport slave (
        input  raddr1, raddr2, we, waddr, wdata, iss_valid, iss_dst, flush,
        output rdata1, busy1, rdata2, busy2, dbg_data
    );
endinterface

// File: rtl/regfile_sb.sv
// 2R/1W register file with per-register busy bits for RAW hazard detection in ID,
// optional write-to-read bypass and a hard-wired zero register.
module regfile_sb #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1,
    parameter int DBG_REG  = 2
) (
    input  logic clk,
    input  logic resetn,
    regfile_sb_if.slave bus
);
    localparam int                DEPTH   = 2 ** ADDR_W;
    localparam bit                ZR      = (ZERO_REG != 0);
    localparam bit                BYP     = (BYPASS != 0);
    localparam logic [ADDR_W-1:0] DBG_IDX = ADDR_W'(DBG_REG);

    logic [DATA_W-1:0] rf [DEPTH];
    logic [DEPTH-1:0]  busy;
    logic [DEPTH-1:0]  busy_nxt;
    logic              wr_en;
    logic              hit1;
    logic              hit2;
    logic              zero1;
    logic              zero2;

    assign wr_en = bus.we && !(ZR && (bus.waddr == '0));

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < DEPTH; i++) begin
                rf[i] <= '0;
            end
        end else if (wr_en) begin
            rf[bus.waddr] <= bus.wdata;
        end
    end

    // Lowest priority first so later assignments override: WB clear, issue, flush, r0.
    always_comb begin
        busy_nxt = busy;
        if (bus.we) begin
            busy_nxt[bus.waddr] = 1'b0;
        end
        if (bus.iss_valid) begin
            busy_nxt[bus.iss_dst] = 1'b1;
        end
        if (bus.flush) begin
            busy_nxt = '0;
        end
        if (ZR) begin
            busy_nxt[0] = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            busy <= '0;
        end else begin
            busy <= busy_nxt;
        end
    end

    assign hit1  = BYP && bus.we && (bus.waddr == bus.raddr1);
    assign hit2  = BYP && bus.we && (bus.waddr == bus.raddr2);
    assign zero1 = ZR && (bus.raddr1 == '0);
    assign zero2 = ZR && (bus.raddr2 == '0);

    // Outputs are forced low during reset so a bypassed write cannot leak through.
    always_comb begin
        bus.rdata1 = '0;
        bus.busy1  = 1'b0;
        if (resetn && !zero1) begin
            bus.rdata1 = hit1 ? bus.wdata : rf[bus.raddr1];
            bus.busy1  = busy[bus.raddr1] && !hit1;
        end
    end

    always_comb begin
        bus.rdata2 = '0;
        bus.busy2  = 1'b0;
        if (resetn && !zero2) begin
            bus.rdata2 = hit2 ? bus.wdata : rf[bus.raddr2];
            bus.busy2  = busy[bus.raddr2] && !hit2;
        end
    end

    assign bus.dbg_data = resetn ? rf[DBG_IDX] : '0;
endmodule

// File: tb/tb_regfile_sb.sv
// Directed test of regfile_sb: one instance with bypass, a second without, both fed the same stimulus.
module tb_regfile_sb;
    logic clk;
    logic resetn;
    int   total;
    int   bad;

    regfile_sb_if #(.DATA_W(32), .ADDR_W(5)) bus_a ();
    regfile_sb_if #(.DATA_W(32), .ADDR_W(5)) bus_b ();

    regfile_sb #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1), .BYPASS(1), .DBG_REG(2)) dut_a (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus_a.slave)
    );

    regfile_sb #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1), .BYPASS(0), .DBG_REG(2)) dut_b (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus_b.slave)
    );

    assign bus_b.raddr1    = bus_a.raddr1;
    assign bus_b.raddr2    = bus_a.raddr2;
    assign bus_b.we        = bus_a.we;
    assign bus_b.waddr     = bus_a.waddr;
    assign bus_b.wdata     = bus_a.wdata;
    assign bus_b.iss_valid = bus_a.iss_valid;
    assign bus_b.iss_dst   = bus_a.iss_dst;
    assign bus_b.flush     = bus_a.flush;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic applyStimulus(input logic we, input logic [4:0] waddr, input logic [31:0] wdata,
                                 input logic iss, input logic [4:0] dst, input logic flush,
                                 input logic [4:0] ra1, input logic [4:0] ra2);
        bus_a.we        = we;
        bus_a.waddr     = waddr;
        bus_a.wdata     = wdata;
        bus_a.iss_valid = iss;
        bus_a.iss_dst   = dst;
        bus_a.flush     = flush;
        bus_a.raddr1    = ra1;
        bus_a.raddr2    = ra2;
        #1;
    endtask

    // Inputs change 2 time units after the rising edge, well away from it.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial begin
        total  = 0;
        bad    = 0;
        resetn = 1'b0;
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 5'd5, 5'd6);
        tick();
        tick();
        checkOutput("rst_rdata1", bus_a.rdata1, 32'h0);
        checkOutput("rst_busy1", 32'(bus_a.busy1), 32'h0);
        checkOutput("rst_dbg", bus_a.dbg_data, 32'h0);
        resetn = 1'b1;

        // r5 = DEAD and issue to r6 in the same cycle
        applyStimulus(1'b1, 5'd5, 32'hDEAD, 1'b1, 5'd6, 1'b0, 5'd5, 5'd6);
        tick();
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 5'd5, 5'd6);
        checkOutput("r5_written", bus_a.rdata1, 32'hDEAD);
        checkOutput("r6_busy", 32'(bus_a.busy2), 32'h1);

        // Asynchronous reset between edges, with a write pending that must be discarded
        resetn = 1'b0;
        applyStimulus(1'b1, 5'd5, 32'h1111, 1'b0, 5'd0, 1'b0, 5'd5, 5'd6);
        checkOutput("midrst_rdata1", bus_a.rdata1, 32'h0);
        checkOutput("midrst_busy2", 32'(bus_a.busy2), 32'h0);
        tick();
        resetn = 1'b1;
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 5'd5, 5'd6);
        checkOutput("postrst_r5", bus_a.rdata1, 32'h0);
        checkOutput("postrst_busy6", 32'(bus_a.busy2), 32'h0);

        // Zero register ignores writes and issues
        applyStimulus(1'b1, 5'd0, 32'hFFFF_FFFF, 1'b0, 5'd0, 1'b0, 5'd0, 5'd0);
        checkOutput("r0_nobypass", bus_a.rdata1, 32'h0);
        tick();
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 1'b0, 5'd0, 5'd0);
        checkOutput("r0_after_write", bus_a.rdata1, 32'h0);
        tick();
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 5'd0, 5'd0);
        checkOutput("r0_never_busy", 32'(bus_a.busy1), 32'h0);

        // Bypass versus no bypass
        applyStimulus(1'b1, 5'd9, 32'h5, 1'b0, 5'd0, 1'b0, 5'd9, 5'd0);
        tick();
        applyStimulus(1'b1, 5'd9, 32'h1234, 1'b0, 5'd0, 1'b0, 5'd9, 5'd0);
        checkOutput("bypass_on", bus_a.rdata1, 32'h1234);
        checkOutput("bypass_off", bus_b.rdata1, 32'h5);
        tick();
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 5'd9, 5'd0);
        checkOutput("r9_stored_b", bus_b.rdata1, 32'h1234);

        // Scoreboard: issue to r13, busy is visible only from the next cycle
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd13, 1'b0, 5'd0, 5'd13);
        checkOutput("issue_same_cycle", 32'(bus_a.busy2), 32'h0);
        tick();
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 5'd0, 5'd13);
        checkOutput("r13_busy_a", 32'(bus_a.busy2), 32'h1);
        checkOutput("r13_busy_b", 32'(bus_b.busy2), 32'h1);
        applyStimulus(1'b1, 5'd13, 32'h7, 1'b0, 5'd0, 1'b0, 5'd0, 5'd13);
        checkOutput("wb13_busy_a", 32'(bus_a.busy2), 32'h0);
        checkOutput("wb13_rdata_a", bus_a.rdata2, 32'h7);
        checkOutput("wb13_busy_b", 32'(bus_b.busy2), 32'h1);
        checkOutput("wb13_rdata_b", bus_b.rdata2, 32'h0);
        tick();
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 5'd0, 5'd13);
        checkOutput("r13_cleared", 32'(bus_a.busy2), 32'h0);

        // Issue and WB on the same register: the issue wins
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd13, 1'b0, 5'd0, 5'd13);
        tick();
        applyStimulus(1'b1, 5'd13, 32'h8, 1'b1, 5'd13, 1'b0, 5'd0, 5'd13);
        tick();
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 5'd0, 5'd13);
        checkOutput("iss_wins_busy", 32'(bus_a.busy2), 32'h1);
        checkOutput("iss_wins_rdata", bus_a.rdata2, 32'h8);

        // Flush beats a same-cycle issue but the write still lands
        applyStimulus(1'b1, 5'd21, 32'h55, 1'b1, 5'd4, 1'b1, 5'd4, 5'd13);
        tick();
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 5'd4, 5'd13);
        checkOutput("flush_busy4", 32'(bus_a.busy1), 32'h0);
        checkOutput("flush_busy13", 32'(bus_a.busy2), 32'h0);
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 5'd21, 5'd13);
        checkOutput("flush_write", bus_a.rdata1, 32'h55);

        // Issue to r10 and WB to r11 in one cycle both take effect
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd11, 1'b0, 5'd10, 5'd11);
        tick();
        applyStimulus(1'b1, 5'd11, 32'h77, 1'b1, 5'd10, 1'b0, 5'd10, 5'd11);
        tick();
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 5'd10, 5'd11);
        checkOutput("dual_busy10", 32'(bus_a.busy1), 32'h1);
        checkOutput("dual_busy11", 32'(bus_a.busy2), 32'h0);
        checkOutput("dual_rdata11", bus_a.rdata2, 32'h77);

        // Debug mirror updates only after the edge
        applyStimulus(1'b1, 5'd2, 32'h00AB, 1'b0, 5'd0, 1'b0, 5'd0, 5'd0);
        checkOutput("dbg_before", bus_a.dbg_data, 32'h0);
        tick();
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 5'd0, 5'd0);
        checkOutput("dbg_after", bus_a.dbg_data, 32'h00AB);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
